// File: rtl/mmio_ram_periph.sv
// Memory-mapped slave for the native mem_valid/mem_ready bus: word RAM,
// LED output channels, a STAT register (sticky error + transaction count),
// a fixed number of wait states and out-of-range error signalling.
module mmio_ram_periph #(
  parameter int unsigned RAM_WORDS   = 1024,
  parameter logic [31:0] PERIPH_BASE = 32'h0000_2000,
  parameter int unsigned NUM_LED_CH  = 1,
  parameter int unsigned LED_WIDTH   = 16,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             mem_valid,
  input  logic [31:0]                      mem_addr,
  input  logic [31:0]                      mem_wdata,
  input  logic [3:0]                       mem_wstrb,
  output logic                             mem_ready,
  output logic [31:0]                      mem_rdata,
  output logic [NUM_LED_CH*LED_WIDTH-1:0]  leds,
  output logic                             err,
  output logic                             busy
);

  localparam int unsigned RAM_AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [29:0] STAT_WORD = PERIPH_BASE[31:2];
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t state, state_nxt;

  logic        run;
  logic        accept;
  logic        commit;
  logic [3:0]  wcnt;

  logic [29:0] req_word;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;

  logic [29:0] cur_word;
  logic [31:0] cur_wdata;
  logic [3:0]  cur_wstrb;
  logic        is_write;

  logic                    ram_hit;
  logic                    stat_hit;
  logic [NUM_LED_CH-1:0]   led_hit;
  logic                    unmapped;
  logic [RAM_AW-1:0]       ram_idx;
  logic [31:0]             byte_mask;
  logic [31:0]             rd_word;
  logic [15:0]             txn_count;

  logic [31:0]             ram    [RAM_WORDS];
  logic [LED_WIDTH-1:0]    led_q  [NUM_LED_CH];

  logic                    addr_unused;

  assign addr_unused = ^mem_addr[1:0];

  // Goes high on the first clock after reset release; keeps the FSM (and
  // therefore every commit, including the untimed RAM write port) frozen
  // while reset is held, so a request seen during reset cannot write RAM.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) run <= 1'b0;
    else         run <= 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic: accept in IDLE, count wait states, one-cycle DONE.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_valid && run) begin
          accept    = 1'b1;
          state_nxt = (WAIT_STATES == 0) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wcnt == '0) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign commit    = (state_nxt == ST_DONE) && (state != ST_DONE);
  assign mem_ready = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

  // Request latch and wait-state counter, loaded on the acceptance edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_word  <= '0;
      req_wdata <= '0;
      req_wstrb <= '0;
      wcnt      <= '0;
    end else if (accept) begin
      req_word  <= mem_addr[31:2];
      req_wdata <= mem_wdata;
      req_wstrb <= mem_wstrb;
      wcnt      <= WAIT_LOAD;
    end else if (state == ST_WAIT && wcnt != '0) begin
      wcnt <= wcnt - 4'd1;
    end
  end

  // With no wait states the commit edge is the acceptance edge, so the live
  // bus is used in IDLE and the latched request everywhere else.
  always_comb begin
    if (state == ST_IDLE) begin
      cur_word  = mem_addr[31:2];
      cur_wdata = mem_wdata;
      cur_wstrb = mem_wstrb;
    end else begin
      cur_word  = req_word;
      cur_wdata = req_wdata;
      cur_wstrb = req_wstrb;
    end
  end

  // Address decode (RAM has priority) and byte-lane mask.
  always_comb begin
    is_write = |cur_wstrb;
    ram_hit  = ({2'b00, cur_word} < RAM_WORDS);
    stat_hit = !ram_hit && (cur_word == STAT_WORD);
    for (int unsigned i = 0; i < NUM_LED_CH; i++) begin
      led_hit[i] = !ram_hit && (cur_word == STAT_WORD + 30'(i + 1));
    end
    unmapped = !ram_hit && !stat_hit && !(|led_hit);
    ram_idx  = cur_word[RAM_AW-1:0];
    for (int unsigned b = 0; b < 4; b++) begin
      byte_mask[8*b +: 8] = {8{cur_wstrb[b]}};
    end
  end

  // Read data mux for the addressed target.
  always_comb begin
    rd_word = ERR_DATA;
    if (ram_hit) begin
      rd_word = ram[ram_idx];
    end else if (stat_hit) begin
      rd_word = {err, 15'b0, txn_count};
    end else begin
      for (int unsigned i = 0; i < NUM_LED_CH; i++) begin
        if (led_hit[i]) rd_word = 32'(led_q[i]);
      end
    end
  end

  // RAM byte-lane writes on the edge entering DONE; contents are not reset.
  always_ff @(posedge clk) begin
    if (commit && ram_hit) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (cur_wstrb[b]) ram[ram_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
      end
    end
  end

  // Register-side commit: count, read capture, sticky error, LED writes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      txn_count <= '0;
      err       <= 1'b0;
      mem_rdata <= '0;
      for (int unsigned i = 0; i < NUM_LED_CH; i++) led_q[i] <= '0;
    end else if (commit) begin
      txn_count <= txn_count + 16'd1;
      if (!is_write) mem_rdata <= rd_word;
      if (unmapped) begin
        err <= 1'b1;
      end else if (stat_hit && cur_wstrb[3] && cur_wdata[31]) begin
        err <= 1'b0;
      end
      for (int unsigned i = 0; i < NUM_LED_CH; i++) begin
        if (led_hit[i] && is_write) begin
          led_q[i] <= LED_WIDTH'((32'(led_q[i]) & ~byte_mask) | (cur_wdata & byte_mask));
        end
      end
    end
  end

  // Pack LED channels, channel 0 in the LSBs.
  always_comb begin
    leds = '0;
    for (int unsigned i = 0; i < NUM_LED_CH; i++) begin
      leds[i*LED_WIDTH +: LED_WIDTH] = led_q[i];
    end
  end

endmodule
